// File: rtl/ext_alu_pkg.sv
// Shared types for the extended-ALU issue sequencer: func encoding, FSM states, latency lookup.
package ext_alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        FN_MUL   = 3'b000,
        FN_UMUL  = 3'b001,
        FN_ADDF  = 3'b010,
        FN_SUBF  = 3'b011,
        FN_MULF  = 3'b100,
        FN_ITF   = 3'b101,
        FN_FTI   = 3'b110,
        FN_UNDEF = 3'b111
    } alu_func_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // FN_UNDEF never issues; returning 1 keeps the caller's LAT-1 arithmetic non-negative.
    function automatic int lat_of(alu_func_t f, int l_mul, int l_umul, int l_addf,
                                  int l_subf, int l_mulf, int l_itf, int l_fti);
        case (f)
            FN_MUL:  return l_mul;
            FN_UMUL: return l_umul;
            FN_ADDF: return l_addf;
            FN_SUBF: return l_subf;
            FN_MULF: return l_mulf;
            FN_ITF:  return l_itf;
            FN_FTI:  return l_fti;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/ext_alu_sequencer.sv
// Issue controller for the multi-cycle extended ALU: holds operands for the op's latency,
// stalls the pipeline meanwhile, then captures result/flags and pulses done.
module ext_alu_sequencer
    import ext_alu_pkg::*;
#(
    parameter int LAT_MUL  = 2,
    parameter int LAT_UMUL = 2,
    parameter int LAT_ADDF = 3,
    parameter int LAT_SUBF = 3,
    parameter int LAT_MULF = 3,
    parameter int LAT_ITF  = 2,
    parameter int LAT_FTI  = 2,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        func,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src0,
    input  logic              flush,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src0,
    output logic [2:0]        alu_func,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ov,
    input  logic              alu_zr,
    input  logic              alu_neg,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              ov,
    output logic              zr,
    output logic              neg,
    output logic              illegal
);

    localparam int CNT_MAX = (2 ** CNT_W) - 1;

    if (LAT_MUL  < 1 || LAT_MUL  > CNT_MAX || LAT_UMUL < 1 || LAT_UMUL > CNT_MAX ||
        LAT_ADDF < 1 || LAT_ADDF > CNT_MAX || LAT_SUBF < 1 || LAT_SUBF > CNT_MAX ||
        LAT_MULF < 1 || LAT_MULF > CNT_MAX || LAT_ITF  < 1 || LAT_ITF  > CNT_MAX ||
        LAT_FTI  < 1 || LAT_FTI  > CNT_MAX) begin : g_bad_lat
        $fatal(1, "ext_alu_sequencer: every LAT_* must lie in 1..2**CNT_W-1");
    end

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             legal;
    logic             issue;
    logic             capture;

    assign legal   = (alu_func_t'(func) != FN_UNDEF);
    // flush wins over a same-cycle start and over the final-cycle capture.
    assign issue   = (state != BUSY) & start & legal & ~flush;
    assign capture = (state == BUSY) & (cnt == '0) & ~flush;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: state_nxt = issue ? BUSY : IDLE;
                BUSY:       state_nxt = (cnt == '0) ? DONE : BUSY;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy  = (state == BUSY);
        done  = (state == DONE);
        stall = ~rst & ((state == BUSY) | issue);
    end

    // Latency counter: loaded with LAT-1 so it reaches zero in the op's last BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (issue) begin
            cnt <= CNT_W'(lat_of(alu_func_t'(func), LAT_MUL, LAT_UMUL, LAT_ADDF, LAT_SUBF,
                                 LAT_MULF, LAT_ITF, LAT_FTI) - 1);
        end else if ((state == BUSY) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_src1 <= '0;
            alu_src0 <= '0;
            alu_func <= '0;
        end else if (issue) begin
            alu_src1 <= src1;
            alu_src0 <= src0;
            alu_func <= func;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            ov     <= 1'b0;
            zr     <= 1'b0;
            neg    <= 1'b0;
        end else if (capture) begin
            result <= alu_result;
            ov     <= alu_ov;
            zr     <= alu_zr;
            neg    <= alu_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) illegal <= 1'b0;
        else     illegal <= (state != BUSY) & start & ~legal & ~flush;
    end

endmodule

// File: tb/tb_ext_alu_sequencer.sv
// Scoreboard bench for ext_alu_sequencer with a latency-accurate ALU stand-in.
module tb_ext_alu_sequencer;
    import ext_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  func;
    logic [31:0] src1, src0;
    logic [31:0] alu_src1, alu_src0;
    logic [2:0]  alu_func;
    logic [31:0] alu_result;
    logic        alu_ov, alu_zr, alu_neg;
    logic        stall, busy, done, ov, zr, neg, illegal;
    logic [31:0] result;

    ext_alu_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .func(func), .src1(src1), .src0(src0),
        .flush(flush), .alu_src1(alu_src1), .alu_src0(alu_src0), .alu_func(alu_func),
        .alu_result(alu_result), .alu_ov(alu_ov), .alu_zr(alu_zr), .alu_neg(alu_neg),
        .stall(stall), .busy(busy), .done(done), .result(result), .ov(ov), .zr(zr),
        .neg(neg), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_ill;
        logic [31:0] res;
        logic        ov, zr, neg;
    } exp_t;

    exp_t        sb[$];
    int          n_pass = 0, n_total = 0;
    int          cyc = 0, iss_cyc = -100, iss_lat = 0;
    logic        exp_stall = 1'b0, exp_busy = 1'b0;
    bit          chk_en = 1'b0;
    logic [31:0] last_res = '0, last_s1 = '0, last_s0 = '0;
    logic [2:0]  last_func = '0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic int lat_ref(logic [2:0] f);
        return (f == 3'd2 || f == 3'd3 || f == 3'd4) ? 3 : 2;
    endfunction

    // What the real ALU would produce: {ov, result}. Integer multiplies are exact,
    // the float ops are a deterministic scramble except the 1.0+2.0 reference case.
    function automatic logic [32:0] alu_model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        logic [31:0]        r;
        ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        pu = {32'b0, a} * {32'b0, b};
        case (f)
            3'd0: return {(ps[63:31] != '0) && (ps[63:31] != '1), ps[31:0]};
            3'd1: return {pu[63:32] != '0, pu[31:0]};
            default: begin
                if (f == 3'd2 && a == 32'h3F800000 && b == 32'h40000000) r = 32'h40400000;
                else r = (a ^ {b[15:0], b[31:16]}) + {29'b0, f} * 32'h9E3779B9;
                return {^r, r};
            end
        endcase
    endfunction

    // ALU stand-in: correct output only in the last cycle of the op's latency window.
    initial begin
        logic [32:0] m;
        alu_result = '0; alu_ov = 0; alu_zr = 0; alu_neg = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (cyc == iss_cyc + iss_lat) begin
                m = alu_model(alu_func, alu_src1, alu_src0);
                alu_result = m[31:0]; alu_ov = m[32];
                alu_zr = (m[31:0] == 0); alu_neg = m[31];
            end else begin
                alu_result = $urandom; alu_ov = 1'($urandom_range(0, 1));
                alu_zr = 1'($urandom_range(0, 1)); alu_neg = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: per-cycle stall/busy and scoreboard pops on done/illegal.
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            chk("stall", {31'b0, stall}, {31'b0, exp_stall});
            chk("busy", {31'b0, busy}, {31'b0, exp_busy});
            if (done || illegal) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", {30'b0, done, illegal}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_kind", {30'b0, done, illegal}, e.is_ill ? 32'd1 : 32'd2);
                    if (!e.is_ill) begin
                        chk("result", result, e.res);
                        chk("flags", {29'b0, ov, zr, neg}, {29'b0, e.ov, e.zr, e.neg});
                    end
                end
            end
        end
    end

    task automatic drive(bit st, logic [2:0] f, logic [31:0] a, logic [31:0] b, bit fl,
                         bit es, bit eb);
        @(posedge clk);
        #1;
        start = st; func = f; src1 = a; src0 = b; flush = fl;
        exp_stall = es; exp_busy = eb;
    endtask

    task automatic idle();
        drive(0, 3'($urandom), $urandom, $urandom, 0, 0, 0);
    endtask

    task automatic check_zero_outputs(string tag);
        chk({tag, "_alu_src1"}, alu_src1, 0);
        chk({tag, "_alu_src0"}, alu_src0, 0);
        chk({tag, "_alu_func"}, {29'b0, alu_func}, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_flags"}, {29'b0, ov, zr, neg}, 0);
        chk({tag, "_ctrl"}, {28'b0, done, illegal, busy, stall}, 0);
    endtask

    // One op issued in the current IDLE/DONE slot. flush_at: -1 none, 0 on the issue
    // cycle, k = k-th BUSY cycle. Returns with the DUT about to be in DONE (or IDLE).
    task automatic run_op(logic [2:0] f, logic [31:0] a, logic [31:0] b, bit hold,
                          int flush_at, bit use_exp, logic [31:0] exp_r);
        int          lat;
        logic [32:0] m;
        exp_t        e;
        lat = lat_ref(f);
        if (f == 3'b111) begin
            drive(1, f, a, b, 0, 0, 0);
            e.is_ill = 1; e.res = '0; e.ov = 0; e.zr = 0; e.neg = 0;
            sb.push_back(e);
            idle();
            chk("ill_alu_func", {29'b0, alu_func}, {29'b0, last_func});
            chk("ill_alu_src", alu_src1 ^ alu_src0, last_s1 ^ last_s0);
            return;
        end
        if (flush_at == 0) begin
            drive(1, f, a, b, 1, 0, 0);
            idle();
            chk("flush_issue_result", result, last_res);
            return;
        end
        drive(1, f, a, b, 0, 1, 0);
        iss_cyc = cyc; iss_lat = lat;
        last_func = f; last_s1 = a; last_s0 = b;
        m = alu_model(f, a, b);
        if (use_exp) m = {1'b0, exp_r};
        if (flush_at < 0) begin
            e.is_ill = 0; e.res = m[31:0]; e.ov = m[32]; e.zr = (m[31:0] == 0); e.neg = m[31];
            sb.push_back(e);
        end
        for (int k = 1; k <= lat; k++) begin
            drive(hold, f, hold ? $urandom : a, hold ? $urandom : b, k == flush_at, 1, 1);
            if (k == flush_at) begin
                idle();
                chk("flush_result_held", result, last_res);
                return;
            end
        end
        last_res = m[31:0];
    endtask

    initial begin
        int f, mode;
        rst = 1; start = 0; flush = 0; func = 0; src1 = 0; src0 = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 0;
        chk_en = 1;

        // MUL 7 * -3
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, 0, -1, 1, 32'hFFFFFFEB);
        idle();
        // ADDF 1.0 + 2.0 issued in the DONE slot of a UMUL
        run_op(3'b001, 32'd100, 32'd5, 0, -1, 0, 0);
        run_op(3'b010, 32'h3F800000, 32'h40000000, 0, -1, 1, 32'h40400000);
        // Illegal func straight from DONE
        run_op(3'b111, 32'h1234, 32'h5678, 0, -1, 0, 0);
        // Flush MULF in its final BUSY cycle
        run_op(3'b100, 32'hDEAD, 32'hBEEF, 0, 3, 0, 0);
        // Reset in the second BUSY cycle of FTI
        drive(1, 3'b110, 32'h11, 32'h22, 0, 1, 0);
        iss_cyc = cyc; iss_lat = 2;
        drive(0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        rst = 1;
        idle();
        rst = 0;
        check_zero_outputs("midop_reset");
        last_res = '0; last_func = '0; last_s1 = '0; last_s0 = '0;
        run_op(3'b101, 32'h42, 32'h7, 0, -1, 0, 0);
        // start held through BUSY with changing operands
        run_op(3'b000, 32'h00010001, 32'h00000300, 1, -1, 0, 0);
        idle();

        repeat (150) begin
            f = $urandom_range(0, 7);
            mode = $urandom_range(0, 9);
            run_op(3'(f), ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                   ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, 1'($urandom_range(0, 1)),
                   (mode == 0) ? $urandom_range(0, lat_ref(3'(f))) : -1, 0, 0);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) idle();
        end

        repeat (4) idle();
        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
